if_stage: RTL and testbench
===========================

IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 SHALL have port clk, input, 1 bit: the single clock.
REQ-002 SHALL have port reset, input, 1 bit: reset, synchronous and active-high.
REQ-003 SHALL have port ds_allowin, input, 1 bit: decode stage can accept an instruction this cycle.
REQ-004 SHALL have port br_bus, input, BR_BUS_WD+1 (34) bits: {is_branch, br_taken, br_target[31:0]}, driven combinationally by decode and qualified by decode-valid.
REQ-005 SHALL have port fs_to_ds_valid, output, 1 bit: fetch slot holds an instruction offered to decode.
REQ-006 SHALL have port fs_to_ds_bus, output, FS_TO_DS_BUS_WD (64) bits: {inst[31:0], fs_pc[31:0]}.
REQ-007 SHALL have port fs_ex_bus, output, FS_EX_BUS_WD (34) bits: {bd, adel, badvaddr[31:0]}.
REQ-008 SHALL have port flush, input, 1 bit: CP0 exception or eret redirect.
REQ-009 SHALL have port flush_pc, input, 32 bits: redirect address, valid only when flush=1.
REQ-010 SHALL have the following instruction-SRAM ports:
- inst_sram_req, output, 1 bit.
- inst_sram_addr, output, 32 bits.
- inst_sram_addr_ok, input, 1 bit.
- inst_sram_data_ok, input, 1 bit.
- inst_sram_rdata, input, 32 bits.

Function
REQ-011 SHALL implement a 4-state FSM:
- REQ: inst_sram_req=1, inst_sram_addr=fetch_pc.
- WAIT: waiting for data_ok.
- HOLD: slot valid.
- DROP: discarding one stale response.
REQ-012 SHALL allow at most one outstanding SRAM transaction, and SHALL accept a handshake as req&&addr_ok in the same cycle.
REQ-013 SHALL hold inst_sram_addr stable while req=1 and addr_ok=0.
REQ-014 SHALL make the following FSM transitions:
- REQ->WAIT on addr_ok.
- WAIT->HOLD on data_ok, capturing rdata into the slot.
- HOLD->REQ when ds_allowin=1.
REQ-015 SHALL drive fs_to_ds_valid=1 only in HOLD, with no flush that cycle.
REQ-016 SHALL always drive fs_pc with the address of the instruction in or being fetched into the slot, including while fs_to_ds_valid=0, because decode computes branch targets from it.
REQ-017 SHALL compute the next fetch address on HOLD->REQ as follows:
- br_target if is_branch&&br_taken&&ds_allowin in that cycle;
- else the pending target if br_pending=1;
- else fs_pc+4.
REQ-018 SHALL set br_pending and latch br_target when is_branch&&br_taken&&ds_allowin occurs while the FSM is not in HOLD (delay slot not yet fetched), and SHALL clear br_pending on the next HOLD->REQ.
REQ-019 SHALL drive bd in fs_ex_bus as is_branch | bd_pending. bd_pending is set on is_branch&&ds_allowin outside HOLD and cleared on HOLD->REQ.
REQ-020 SHALL treat a fetch address with fetch_pc[1:0]!=0 as follows:
- no request issued;
- REQ goes directly to HOLD with inst=0, adel=1 and badvaddr=fetch_pc.
REQ-021 SHALL drive adel=0 and badvaddr=fs_pc for an aligned fetch.
REQ-022 SHALL, on flush=1 in any state:
- set fetch_pc=flush_pc;
- clear br_pending, bd_pending and slot valid;
- go to DROP if a transaction is outstanding (WAIT, or REQ with addr_ok the same cycle), else go to REQ.
REQ-023 SHALL, in DROP, drive req=0, leave DROP on data_ok, discard that rdata, then go to REQ.
REQ-024 SHALL apply a flush that coincides with data_ok while in WAIT by discarding the data and going straight to REQ.
REQ-025 SHALL give flush priority over branch capture and over ds_allowin when both occur in the same cycle.
REQ-026 SHALL ignore br_bus while is_branch=0.

Reset
REQ-027 SHALL, with reset=1, set the FSM to REQ and fetch_pc to 32'hBFC00000.
REQ-028 SHALL, with reset=1, drive fs_to_ds_valid=0 and clear br_pending and bd_pending.
REQ-029 SHALL drive inst_sram_req=0 during reset and assert it the first cycle after reset deasserts.
REQ-030 SHALL abandon any outstanding transaction when reset is asserted mid-transaction, with no DROP; the memory bridge is reset together with this block.

Structure
REQ-031 SHALL take BR_BUS_WD, FS_TO_DS_BUS_WD, FS_EX_BUS_WD, the reset vector and the FSM state encodings from the shared header mycpu.h.
REQ-032 SHALL be a single module with no sub-modules, because the FSM and PC logic are too small to justify a split.

Verification
REQ-033 SHALL verify reset boot: after release with addr_ok=1 and data_ok one cycle later (rdata=32'h24010001), fs_to_ds_bus = {32'h24010001, 32'hBFC00000} with fs_to_ds_valid=1, and the next request is to 32'hBFC00004.
REQ-034 SHALL verify backpressure: holding ds_allowin=0 for 5 cycles keeps HOLD and keeps the bus stable with req=0. Releasing it issues a request to fs_pc+4.
REQ-035 SHALL verify a taken branch with the delay slot late: the branch is captured (target 32'hBFC00100) while in WAIT. The delay slot then carries bd=1, and the following request is to 32'hBFC00100.
REQ-036 SHALL verify a same-cycle branch: is_branch&&br_taken&&ds_allowin occurs in HOLD. The next request is to br_target and br_pending stays 0.
REQ-037 SHALL verify a flush during WAIT (flush_pc=32'hBFC00380): the FSM goes to DROP, the stale rdata never appears with valid=1, and the next request is to 32'hBFC00380.
REQ-038 SHALL verify a misaligned jr target (32'hBFC00102): no request is issued, and the slot shows adel=1, badvaddr=32'hBFC00102, inst=0.

Source files
------------

// File: rtl/if_stage_pkg.sv
// rtl/if_stage_pkg.sv - shared fetch-stage widths, reset vector and FSM encodings
// Purpose: common definitions used by the fetch stage and its testbench.
// Ports: none (package).
package if_stage_pkg;

    // br_bus carries one extra flag bit on top of BR_BUS_WD: {is_branch, br_taken, br_target}
    localparam int BR_BUS_WD       = 33;
    localparam int FS_TO_DS_BUS_WD = 64;
    localparam int FS_EX_BUS_WD    = 34;

    localparam logic [31:0] RESET_VECTOR = 32'hBFC00000;

    typedef enum logic [1:0] {
        FS_REQ  = 2'd0,
        FS_WAIT = 2'd1,
        FS_HOLD = 2'd2,
        FS_DROP = 2'd3
    } fs_state_t;

endpackage

// File: rtl/if_stage_if.sv
// rtl/if_stage_if.sv - instruction SRAM request/response interface
// Purpose: groups the instruction-SRAM handshake signals.
// Ports (master = fetch stage): inst_sram_req/addr out; addr_ok/data_ok/rdata in.
interface if_stage_if;

    logic        inst_sram_req;
    logic [31:0] inst_sram_addr;
    logic        inst_sram_addr_ok;
    logic        inst_sram_data_ok;
    logic [31:0] inst_sram_rdata;

    modport master (
        output inst_sram_req,
        output inst_sram_addr,
        input  inst_sram_addr_ok,
        input  inst_sram_data_ok,
        input  inst_sram_rdata
    );

    modport slave (
        input  inst_sram_req,
        input  inst_sram_addr,
        output inst_sram_addr_ok,
        output inst_sram_data_ok,
        output inst_sram_rdata
    );

endinterface

// File: rtl/if_stage.sv
// rtl/if_stage.sv - instruction fetch stage with single-outstanding SRAM FSM
// Purpose: fetches one instruction at a time into a single slot offered to decode,
//          tracking branch targets / delay slots and CP0 flush redirects.
// Ports: clk, reset (sync, active-high); ds_allowin, br_bus from decode;
//        fs_to_ds_valid/fs_to_ds_bus/fs_ex_bus to decode; flush/flush_pc from CP0;
//        inst_sram (if_stage_if.master) to the instruction memory bridge.
module if_stage
    import if_stage_pkg::*;
(
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       ds_allowin,
    input  logic [BR_BUS_WD:0]         br_bus,
    output logic                       fs_to_ds_valid,
    output logic [FS_TO_DS_BUS_WD-1:0] fs_to_ds_bus,
    output logic [FS_EX_BUS_WD-1:0]    fs_ex_bus,
    input  logic                       flush,
    input  logic [31:0]                flush_pc,
    if_stage_if.master                 inst_sram
);

    fs_state_t   state;
    fs_state_t   state_next;

    // fetch_pc is both the address being requested and the pc of the slot contents
    logic [31:0] fetch_pc;
    logic [31:0] fetch_pc_next;
    logic [31:0] inst;
    logic [31:0] inst_next;
    logic        br_pending;
    logic        br_pending_next;
    logic [31:0] br_target_q;
    logic [31:0] br_target_next;
    logic        bd_pending;
    logic        bd_pending_next;

    logic        is_branch;
    logic        br_taken;
    logic [31:0] br_target;
    logic        br_take;
    logic        misaligned;
    logic        req;
    logic        handshake;

    assign is_branch  = br_bus[BR_BUS_WD];
    assign br_taken   = br_bus[BR_BUS_WD-1];
    assign br_target  = br_bus[31:0];
    assign br_take    = is_branch && br_taken && ds_allowin;
    assign misaligned = (fetch_pc[1:0] != 2'b00);

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= FS_REQ;
            fetch_pc    <= RESET_VECTOR;
            inst        <= 32'd0;
            br_pending  <= 1'b0;
            br_target_q <= 32'd0;
            bd_pending  <= 1'b0;
        end else begin
            state       <= state_next;
            fetch_pc    <= fetch_pc_next;
            inst        <= inst_next;
            br_pending  <= br_pending_next;
            br_target_q <= br_target_next;
            bd_pending  <= bd_pending_next;
        end
    end

    always_comb begin
        state_next      = state;
        fetch_pc_next   = fetch_pc;
        inst_next       = inst;
        br_pending_next = br_pending;
        br_target_next  = br_target_q;
        bd_pending_next = bd_pending;

        // A misaligned address never reaches the memory; reset masks req so the
        // bridge sees nothing until the first cycle after release.
        req       = (state == FS_REQ) && !misaligned && !reset;
        handshake = req && inst_sram.inst_sram_addr_ok;

        if (flush) begin
            fetch_pc_next   = flush_pc;
            br_pending_next = 1'b0;
            bd_pending_next = 1'b0;
            // A response still owed by the memory must be swallowed in DROP;
            // data_ok arriving this very cycle settles it, so go straight to REQ.
            if (handshake ||
                ((state == FS_WAIT || state == FS_DROP) && !inst_sram.inst_sram_data_ok)) begin
                state_next = FS_DROP;
            end else begin
                state_next = FS_REQ;
            end
        end else begin
            // Branch seen before the delay slot is in the slot: remember the
            // target and that the next slot is a delay slot.
            if (state != FS_HOLD) begin
                if (br_take) begin
                    br_pending_next = 1'b1;
                    br_target_next  = br_target;
                end
                if (is_branch && ds_allowin) begin
                    bd_pending_next = 1'b1;
                end
            end

            case (state)
                FS_REQ: begin
                    if (misaligned) begin
                        state_next = FS_HOLD;
                        inst_next  = 32'd0;
                    end else if (handshake) begin
                        state_next = FS_WAIT;
                    end
                end
                FS_WAIT: begin
                    if (inst_sram.inst_sram_data_ok) begin
                        state_next = FS_HOLD;
                        inst_next  = inst_sram.inst_sram_rdata;
                    end
                end
                FS_HOLD: begin
                    if (ds_allowin) begin
                        state_next      = FS_REQ;
                        br_pending_next = 1'b0;
                        bd_pending_next = 1'b0;
                        if (br_take) begin
                            fetch_pc_next = br_target;
                        end else if (br_pending) begin
                            fetch_pc_next = br_target_q;
                        end else begin
                            fetch_pc_next = fetch_pc + 32'd4;
                        end
                    end
                end
                FS_DROP: begin
                    if (inst_sram.inst_sram_data_ok) begin
                        state_next = FS_REQ;
                    end
                end
                default: state_next = FS_REQ;
            endcase
        end
    end

    assign inst_sram.inst_sram_req  = req;
    assign inst_sram.inst_sram_addr = fetch_pc;

    assign fs_to_ds_valid = (state == FS_HOLD) && !flush && !reset;
    assign fs_to_ds_bus   = {inst, fetch_pc};
    // badvaddr equals the slot pc in both the aligned and misaligned cases
    assign fs_ex_bus      = {is_branch | bd_pending, misaligned, fetch_pc};

endmodule

// File: tb/tb_if_stage.sv
// tb/tb_if_stage.sv - scoreboard testbench for if_stage
module tb_if_stage;
    import if_stage_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        ds_allowin = 1'b0;
    logic [33:0] br_bus = 34'd0;
    logic        flush = 1'b0;
    logic [31:0] flush_pc = 32'd0;
    logic        fs_to_ds_valid;
    logic [63:0] fs_to_ds_bus;
    logic [33:0] fs_ex_bus;

    if_stage_if sram ();

    int total = 0;
    int bad = 0;

    logic [31:0] exp_req[$];
    logic [97:0] exp_slot[$];

    always #5 clk = ~clk;

    if_stage dut (
        .clk            (clk),
        .reset          (reset),
        .ds_allowin     (ds_allowin),
        .br_bus         (br_bus),
        .fs_to_ds_valid (fs_to_ds_valid),
        .fs_to_ds_bus   (fs_to_ds_bus),
        .fs_ex_bus      (fs_ex_bus),
        .flush          (flush),
        .flush_pc       (flush_pc),
        .inst_sram      (sram)
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a == RESET_VECTOR) ? 32'h24010001 : (a ^ 32'h13579BDF);
    endfunction

    function automatic logic [97:0] slot(input logic [31:0] inst, input logic [31:0] pc,
                                         input logic bd, input logic adel);
        return {inst, pc, bd, adel, pc};
    endfunction

    // Scoreboard: requests and slot transfers are compared as the DUT produces them
    always @(negedge clk) begin
        if (!reset && sram.inst_sram_req && sram.inst_sram_addr_ok) begin
            if (exp_req.size() == 0) check("req_unexpected", exp_req.size(), 1);
            else check("req_addr", sram.inst_sram_addr, exp_req.pop_front());
        end
        if (!reset && fs_to_ds_valid && ds_allowin) begin
            if (exp_slot.size() == 0) check("slot_unexpected", exp_slot.size(), 1);
            else check("slot", {fs_to_ds_bus, fs_ex_bus}, exp_slot.pop_front());
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic fetch(input logic [31:0] a, input int stall, input logic [33:0] wait_br);
        exp_req.push_back(a);
        sram.inst_sram_addr_ok = 1'b0;
        for (int i = 0; i < stall; i++) begin
            #1;
            check("stall_req", sram.inst_sram_req, 1'b1);
            check("stall_addr", sram.inst_sram_addr, a);
            cyc();
        end
        sram.inst_sram_addr_ok = 1'b1;
        cyc();
        sram.inst_sram_addr_ok = 1'b0;
        if (wait_br != 34'd0) begin
            br_bus = wait_br;
            ds_allowin = 1'b1;
            cyc();
            br_bus = 34'd0;
            ds_allowin = 1'b0;
        end
        sram.inst_sram_data_ok = 1'b1;
        sram.inst_sram_rdata = mem_word(a);
        cyc();
        sram.inst_sram_data_ok = 1'b0;
    endtask

    task automatic accept(input logic [33:0] br);
        br_bus = br;
        ds_allowin = 1'b1;
        cyc();
        br_bus = 34'd0;
        ds_allowin = 1'b0;
    endtask

    initial begin
        sram.inst_sram_addr_ok = 1'b0;
        sram.inst_sram_data_ok = 1'b0;
        sram.inst_sram_rdata = 32'd0;

        // reset and boot fetch
        repeat (3) cyc();
        check("rst_req", sram.inst_sram_req, 1'b0);
        check("rst_valid", fs_to_ds_valid, 1'b0);
        reset = 1'b0;
        #1;
        check("boot_req", sram.inst_sram_req, 1'b1);
        check("boot_addr", sram.inst_sram_addr, 32'hBFC00000);
        fetch(32'hBFC00000, 0, 34'd0);
        #1;
        check("boot_valid", fs_to_ds_valid, 1'b1);
        check("boot_bus", fs_to_ds_bus, {32'h24010001, 32'hBFC00000});
        exp_slot.push_back(slot(32'h24010001, 32'hBFC00000, 1'b0, 1'b0));
        accept(34'd0);

        // backpressure, with addr_ok stalled 2 cycles
        fetch(32'hBFC00004, 2, 34'd0);
        for (int i = 0; i < 5; i++) begin
            #1;
            check("bp_valid", fs_to_ds_valid, 1'b1);
            check("bp_req", sram.inst_sram_req, 1'b0);
            check("bp_bus", fs_to_ds_bus, {mem_word(32'hBFC00004), 32'hBFC00004});
            cyc();
        end
        exp_slot.push_back(slot(mem_word(32'hBFC00004), 32'hBFC00004, 1'b0, 1'b0));
        accept(34'd0);

        // taken branch captured during WAIT: delay slot gets bd, then target
        fetch(32'hBFC00008, 0, {2'b11, 32'hBFC00100});
        #1;
        check("late_bd", fs_ex_bus[33], 1'b1);
        exp_slot.push_back(slot(mem_word(32'hBFC00008), 32'hBFC00008, 1'b1, 1'b0));
        accept(34'd0);

        // same-cycle branch in HOLD, then sequential fetch shows no stale pending
        fetch(32'hBFC00100, 0, 34'd0);
        exp_slot.push_back(slot(mem_word(32'hBFC00100), 32'hBFC00100, 1'b1, 1'b0));
        accept({2'b11, 32'hBFC00200});
        fetch(32'hBFC00200, 0, 34'd0);
        exp_slot.push_back(slot(mem_word(32'hBFC00200), 32'hBFC00200, 1'b0, 1'b0));
        accept(34'd0);

        // flush during WAIT -> DROP, stale data swallowed
        exp_req.push_back(32'hBFC00204);
        sram.inst_sram_addr_ok = 1'b1;
        cyc();
        sram.inst_sram_addr_ok = 1'b0;
        flush = 1'b1;
        flush_pc = 32'hBFC00380;
        ds_allowin = 1'b1;
        #1;
        check("flush_valid", fs_to_ds_valid, 1'b0);
        cyc();
        flush = 1'b0;
        #1;
        check("drop_req", sram.inst_sram_req, 1'b0);
        cyc();
        sram.inst_sram_data_ok = 1'b1;
        sram.inst_sram_rdata = mem_word(32'hBFC00204);
        #1;
        check("drop_valid", fs_to_ds_valid, 1'b0);
        check("drop_req2", sram.inst_sram_req, 1'b0);
        cyc();
        sram.inst_sram_data_ok = 1'b0;
        ds_allowin = 1'b0;
        #1;
        check("redir_req", sram.inst_sram_req, 1'b1);
        check("redir_addr", sram.inst_sram_addr, 32'hBFC00380);
        fetch(32'hBFC00380, 0, 34'd0);

        // misaligned jr target
        exp_slot.push_back(slot(mem_word(32'hBFC00380), 32'hBFC00380, 1'b1, 1'b0));
        accept({2'b11, 32'hBFC00102});
        check("mis_noreq", sram.inst_sram_req, 1'b0);
        exp_slot.push_back(slot(32'd0, 32'hBFC00102, 1'b0, 1'b1));
        cyc();
        #1;
        check("mis_valid", fs_to_ds_valid, 1'b1);
        check("mis_req", sram.inst_sram_req, 1'b0);
        check("mis_ex", fs_ex_bus, {1'b0, 1'b1, 32'hBFC00102});
        check("mis_inst", fs_to_ds_bus[63:32], 32'd0);
        accept(34'd0);

        // flush in REQ with nothing outstanding goes straight to REQ
        flush = 1'b1;
        flush_pc = 32'hBFC00000;
        cyc();
        flush = 1'b0;
        #1;
        check("fl_req", sram.inst_sram_req, 1'b1);
        check("fl_addr", sram.inst_sram_addr, 32'hBFC00000);

        // flush coinciding with data_ok in WAIT: no DROP
        exp_req.push_back(32'hBFC00000);
        sram.inst_sram_addr_ok = 1'b1;
        cyc();
        sram.inst_sram_addr_ok = 1'b0;
        sram.inst_sram_data_ok = 1'b1;
        sram.inst_sram_rdata = mem_word(32'hBFC00000);
        flush = 1'b1;
        flush_pc = 32'hBFC00010;
        ds_allowin = 1'b1;
        cyc();
        sram.inst_sram_data_ok = 1'b0;
        flush = 1'b0;
        ds_allowin = 1'b0;
        #1;
        check("fldo_req", sram.inst_sram_req, 1'b1);
        check("fldo_addr", sram.inst_sram_addr, 32'hBFC00010);

        // reset mid-transaction abandons it
        exp_req.push_back(32'hBFC00010);
        sram.inst_sram_addr_ok = 1'b1;
        cyc();
        sram.inst_sram_addr_ok = 1'b0;
        reset = 1'b1;
        #1;
        check("rst2_req", sram.inst_sram_req, 1'b0);
        check("rst2_valid", fs_to_ds_valid, 1'b0);
        cyc();
        cyc();
        reset = 1'b0;
        #1;
        check("rst2_boot_req", sram.inst_sram_req, 1'b1);
        check("rst2_boot_addr", sram.inst_sram_addr, 32'hBFC00000);

        check("req_queue_left", exp_req.size(), 0);
        check("slot_queue_left", exp_slot.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
